// File: rtl/uart_pkg.sv
// Shared definitions for the UART register bridge and host-side models.
// Holds the 3-bit parser state encoding and the default command/response
// byte values (opcodes 'W'/'R', ACK, NAK).
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_ADDR = 3'd1,
    ST_GET_DATA = 3'd2,
    ST_BUS      = 3'd3,
    ST_RESP     = 3'd4,
    ST_TXWAIT   = 3'd5
  } state_t;

  localparam logic [7:0] OP_WR_DEF = 8'h57;  // 'W'
  localparam logic [7:0] OP_RD_DEF = 8'h52;  // 'R'
  localparam logic [7:0] ACK_DEF   = 8'h06;
  localparam logic [7:0] NAK_DEF   = 8'h15;

  localparam int TIMEOUT_DEF = 250000;

endpackage

// File: rtl/uart_tx_handoff.sv
// Response hand-off to the UART transmitter.
// Holds the response byte from the moment it is loaded until the next load,
// issues a single start pulse once the transmitter is idle, then tracks the
// transmitter going busy and back to idle before reporting done.
// Ports:
//   clkin, rstnin   clock / async active-low reset
//   load, load_byte capture the response byte (on entry to RESP)
//   in_resp         parser is in RESP (waiting for an idle transmitter)
//   in_txwait       parser is in TXWAIT (frame in flight)
//   txrdyin         transmitter idle flag
//   txdataout       held response byte
//   txstartout      one-cycle transmit request
//   done            transmitter went busy and has returned to idle
module uart_tx_handoff (
  input  logic       clkin,
  input  logic       rstnin,
  input  logic       load,
  input  logic [7:0] load_byte,
  input  logic       in_resp,
  input  logic       in_txwait,
  input  logic       txrdyin,
  output logic [7:0] txdataout,
  output logic       txstartout,
  output logic       done
);

  logic seen_low;

  always_ff @(posedge clkin or negedge rstnin) begin
    if (!rstnin) begin
      txdataout  <= 8'h00;
      txstartout <= 1'b0;
      seen_low   <= 1'b0;
    end else begin
      // Only loaded when entering RESP, so the byte stays put for the frame.
      if (load) txdataout <= load_byte;
      // The parser leaves RESP on the same edge, so this is a single pulse.
      txstartout <= in_resp & txrdyin;
      // The start pulse lands in the first TXWAIT cycle, when the UART may
      // still report idle; require a low before accepting the high.
      seen_low   <= in_txwait & (seen_low | ~txrdyin);
    end
  end

  assign done = in_txwait & seen_low & txrdyin;

endmodule

// File: rtl/uart_reg_bridge.sv
// UART command responder: decodes 'W' addr data / 'R' addr commands from
// received bytes, performs one register-bus access and sends back a single
// response byte (ACK for writes, read data for reads, NAK for bad opcode or
// framing error). A stalled command is dropped silently after TIMEOUT_CLKS.
// Ports:
//   clkin, rstnin             clock / async active-low reset
//   rxdatain, rxrdyin,rxerrin UART receive side
//   txrdyin, txdataout,
//   txstartout                UART transmit handshake
//   regaddrout, regwdataout,
//   regweout, regreout,
//   regrdatain                internal register bus
//   busyout                   command in progress
module uart_reg_bridge
  import uart_pkg::*;
#(
  parameter int         TIMEOUT_CLKS = TIMEOUT_DEF,
  parameter logic [7:0] OP_WR        = OP_WR_DEF,
  parameter logic [7:0] OP_RD        = OP_RD_DEF,
  parameter logic [7:0] ACK          = ACK_DEF,
  parameter logic [7:0] NAK          = NAK_DEF
) (
  input  logic       clkin,
  input  logic       rstnin,
  input  logic [7:0] rxdatain,
  input  logic       rxrdyin,
  input  logic       rxerrin,
  input  logic       txrdyin,
  output logic [7:0] txdataout,
  output logic       txstartout,
  output logic [7:0] regaddrout,
  output logic [7:0] regwdataout,
  output logic       regweout,
  output logic       regreout,
  input  logic [7:0] regrdatain,
  output logic       busyout
);

  localparam int            CW      = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] TMO_LIM = CW'(TIMEOUT_CLKS);

  state_t        state, state_nxt;
  logic          is_wr;
  logic          bus_ph;      // read: 0 = strobe cycle, 1 = data cycle
  logic [CW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          in_get;
  logic          resp_load;
  logic [7:0]    resp_byte;
  logic          in_resp, in_txwait, tx_done;

  assign tmo_hit = (tmo_cnt == TMO_LIM);
  assign in_get  = (state == ST_GET_ADDR) || (state == ST_GET_DATA);

  // State register
  always_ff @(posedge clkin or negedge rstnin) begin
    if (!rstnin) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next state and the response byte to load on entry to RESP
  always_comb begin
    state_nxt = state;
    resp_byte = NAK;
    case (state)
      ST_IDLE: begin
        if (rxrdyin) begin
          if (rxdatain == OP_WR || rxdatain == OP_RD) state_nxt = ST_GET_ADDR;
          else                                        state_nxt = ST_RESP;
        end
      end
      ST_GET_ADDR: begin
        // A received byte beats a simultaneous timeout expiry.
        if (rxerrin)      state_nxt = ST_RESP;
        else if (rxrdyin) state_nxt = is_wr ? ST_GET_DATA : ST_BUS;
        else if (tmo_hit) state_nxt = ST_IDLE;
      end
      ST_GET_DATA: begin
        if (rxerrin)      state_nxt = ST_RESP;
        else if (rxrdyin) state_nxt = ST_BUS;
        else if (tmo_hit) state_nxt = ST_IDLE;
      end
      ST_BUS: begin
        if (is_wr) begin
          state_nxt = ST_RESP;
          resp_byte = ACK;
        end else if (bus_ph) begin
          state_nxt = ST_RESP;
          resp_byte = regrdatain;
        end
      end
      ST_RESP:   if (txrdyin) state_nxt = ST_TXWAIT;
      ST_TXWAIT: if (tx_done) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign resp_load = (state_nxt == ST_RESP) && (state != ST_RESP);

  // Outputs decoded from state
  always_comb begin
    regweout  = (state == ST_BUS) &  is_wr;
    regreout  = (state == ST_BUS) & ~is_wr & ~bus_ph;
    busyout   = (state != ST_IDLE);
    in_resp   = (state == ST_RESP);
    in_txwait = (state == ST_TXWAIT);
  end

  // Command datapath and inter-byte timeout
  always_ff @(posedge clkin or negedge rstnin) begin
    if (!rstnin) begin
      is_wr       <= 1'b0;
      bus_ph      <= 1'b0;
      regaddrout  <= 8'h00;
      regwdataout <= 8'h00;
      tmo_cnt     <= '0;
    end else begin
      if (state == ST_IDLE && rxrdyin) is_wr <= (rxdatain == OP_WR);
      bus_ph <= (state == ST_BUS) ? ~bus_ph : 1'b0;
      if (state == ST_GET_ADDR && rxrdyin && !rxerrin) regaddrout  <= rxdatain;
      if (state == ST_GET_DATA && rxrdyin && !rxerrin) regwdataout <= rxdatain;
      if (rxrdyin || !in_get) tmo_cnt <= '0;
      else if (!tmo_hit)      tmo_cnt <= tmo_cnt + CW'(1);
    end
  end

  uart_tx_handoff u_tx (
    .clkin      (clkin),
    .rstnin     (rstnin),
    .load       (resp_load),
    .load_byte  (resp_byte),
    .in_resp    (in_resp),
    .in_txwait  (in_txwait),
    .txrdyin    (txrdyin),
    .txdataout  (txdataout),
    .txstartout (txstartout),
    .done       (tx_done)
  );

endmodule

// File: tb/tb_uart_reg_bridge.sv
module tb_uart_reg_bridge;
  import uart_pkg::*;

  logic       clkin = 1'b0;
  logic       rstnin;
  logic [7:0] rxdatain;
  logic       rxrdyin;
  logic       rxerrin;
  logic       txrdyin;
  logic [7:0] txdataout;
  logic       txstartout;
  logic [7:0] regaddrout;
  logic [7:0] regwdataout;
  logic       regweout;
  logic       regreout;
  logic [7:0] regrdatain;
  logic       busyout;

  int vecs = 0;
  int errs = 0;

  int         cyc = 0;
  int         n_we = 0, n_re = 0, n_tx = 0;
  int         t_re = 0, t_tx = 0;
  logic [7:0] last_tx = 8'h00;
  logic [7:0] we_addr = 8'h00, we_data = 8'h00;
  int         tx_unstable = 0;
  logic [7:0] rd_val = 8'h00;

  uart_reg_bridge #(.TIMEOUT_CLKS(100)) dut (
    .clkin       (clkin),
    .rstnin      (rstnin),
    .rxdatain    (rxdatain),
    .rxrdyin     (rxrdyin),
    .rxerrin     (rxerrin),
    .txrdyin     (txrdyin),
    .txdataout   (txdataout),
    .txstartout  (txstartout),
    .regaddrout  (regaddrout),
    .regwdataout (regwdataout),
    .regweout    (regweout),
    .regreout    (regreout),
    .regrdatain  (regrdatain),
    .busyout     (busyout)
  );

  always #5 clkin = ~clkin;

  // Strobe monitor, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clkin);
      cyc++;
      if (regweout) begin n_we++; we_addr = regaddrout; we_data = regwdataout; end
      if (regreout) begin n_re++; t_re = cyc; end
      if (txstartout) begin n_tx++; t_tx = cyc; end
    end
  end

  // Register-bus read responder: data valid only in the cycle after the strobe.
  initial begin
    regrdatain = 8'hEE;
    forever begin
      @(negedge clkin);
      if (regreout) begin
        @(posedge clkin); #1 regrdatain = rd_val;
        @(posedge clkin); #1 regrdatain = 8'hEE;
      end
    end
  end

  // UART transmitter model: busy for 8 cycles per frame, checks byte hold.
  initial begin
    txrdyin = 1'b1;
    forever begin
      @(negedge clkin);
      if (txstartout) begin
        last_tx = txdataout;
        txrdyin = 1'b0;
        repeat (8) begin
          @(negedge clkin);
          if (txdataout !== last_tx) tx_unstable++;
        end
        txrdyin = 1'b1;
        @(negedge clkin);
        if (txdataout !== last_tx) tx_unstable++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clkin);
    rxdatain = b;
    rxrdyin  = 1'b1;
    @(negedge clkin);
    rxrdyin  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busyout !== 1'b0 && k < 300) begin
      @(negedge clkin);
      k++;
    end
    chk(tag, 32'(busyout !== 1'b0), 32'd0);
    repeat (3) @(negedge clkin);
  endtask

  int we0, re0, tx0;

  initial begin
    rstnin = 1'b0; rxdatain = 8'h00; rxrdyin = 1'b0; rxerrin = 1'b0;
    repeat (3) @(negedge clkin);
    chk("reset_outs", {busyout, txstartout, regweout, regreout, txdataout, regaddrout, regwdataout},
        32'd0);
    rstnin = 1'b1;
    repeat (2) @(negedge clkin);

    // Write 57 10 A5
    send_byte(8'h57);
    chk("wr_busy_after_op", 32'(busyout), 32'd1);
    send_byte(8'h10);
    send_byte(8'hA5);
    chk("wr_we_latency", 32'(regweout), 32'd1);
    chk("wr_addr_data", {regaddrout, regwdataout}, 32'h10A5);
    @(negedge clkin);
    chk("wr_we_one_cycle", 32'(regweout), 32'd0);
    wait_idle("wr_idle_wait");
    chk("wr_counts", {8'(n_we), 8'(n_re), 8'(n_tx)}, 32'h010001);
    chk("wr_ack", 32'(last_tx), 32'h06);
    chk("wr_tx_stable", 32'(tx_unstable), 32'd0);

    // Read 52 3C -> C3
    rd_val = 8'hC3;
    send_byte(8'h52);
    send_byte(8'h3C);
    chk("rd_re_latency", 32'(regreout), 32'd1);
    chk("rd_addr", 32'(regaddrout), 32'h3C);
    @(negedge clkin);
    chk("rd_re_one_cycle", 32'(regreout), 32'd0);
    wait_idle("rd_idle_wait");
    chk("rd_counts", {8'(n_we), 8'(n_re), 8'(n_tx)}, 32'h010102);
    chk("rd_data", 32'(last_tx), 32'hC3);
    chk("rd_tx_latency", 32'(t_tx - t_re), 32'd3);
    chk("rd_tx_stable", 32'(tx_unstable), 32'd0);

    // Bad opcode 41 -> NAK, then read 52 01 -> 5A
    send_byte(8'h41);
    wait_idle("bad_idle_wait");
    chk("bad_counts", {8'(n_we), 8'(n_re), 8'(n_tx)}, 32'h010103);
    chk("bad_nak", 32'(last_tx), 32'h15);
    rd_val = 8'h5A;
    send_byte(8'h52);
    send_byte(8'h01);
    wait_idle("bad_rd_idle_wait");
    chk("bad_then_rd", {8'(n_re), last_tx, regaddrout}, 32'h025A01);

    // Timeout: 57 10 then silence
    we0 = n_we; tx0 = n_tx;
    send_byte(8'h57);
    send_byte(8'h10);
    repeat (90) @(negedge clkin);
    chk("tmo_still_busy", 32'(busyout), 32'd1);
    repeat (30) @(negedge clkin);
    chk("tmo_dropped", 32'(busyout), 32'd0);
    chk("tmo_no_activity", {8'(n_we - we0), 8'(n_tx - tx0)}, 32'd0);
    send_byte(8'h57);
    send_byte(8'h22);
    send_byte(8'h01);
    wait_idle("tmo_wr_idle_wait");
    chk("tmo_then_wr", {8'(n_we - we0), we_addr, we_data}, 32'h012201);
    chk("tmo_then_ack", 32'(last_tx), 32'h06);

    // Framing error in GET_DATA, extra byte during TXWAIT
    we0 = n_we; tx0 = n_tx;
    send_byte(8'h57);
    send_byte(8'h33);
    @(negedge clkin);
    rxerrin = 1'b1;
    @(negedge clkin);
    rxerrin = 1'b0;
    begin
      int k = 0;
      while (txrdyin !== 1'b0 && k < 50) begin @(negedge clkin); k++; end
      chk("ferr_tx_started", 32'(txrdyin), 32'd0);
    end
    send_byte(8'h57);
    wait_idle("ferr_idle_wait");
    chk("ferr_nak", 32'(last_tx), 32'h15);
    chk("ferr_counts", {8'(n_we - we0), 8'(n_tx - tx0)}, 32'h0001);
    repeat (5) @(negedge clkin);
    chk("ferr_extra_dropped", 32'(busyout), 32'd0);

    // Reset mid-command
    we0 = n_we; tx0 = n_tx;
    send_byte(8'h57);
    send_byte(8'h10);
    rstnin = 1'b0;
    @(negedge clkin);
    chk("rst_outs_zero", {busyout, txstartout, regweout, regreout, txdataout, regaddrout, regwdataout},
        32'd0);
    repeat (2) @(negedge clkin);
    rstnin = 1'b1;
    send_byte(8'h7F);
    wait_idle("rst_idle_wait");
    chk("rst_nak", 32'(last_tx), 32'h15);
    chk("rst_counts", {8'(n_we - we0), 8'(n_tx - tx0)}, 32'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=hung expected=done");
    $fatal(1, "simulation time limit");
  end

endmodule
